// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the LEGv8 memory stage.
//   REG_W        : width of a register specifier (rd)
//   mem_state_t  : state of the data-memory access controller
//   ctrl_m_t     : control bits carried by the EX/MEM pipeline register
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FAULT = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic branch;
        logic memRead;
        logic memWrite;
        logic regWrite;
        logic memtoReg;
    } ctrl_m_t;

endpackage

// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Request/acknowledge bus between the memory stage and the data memory.
//   master : the pipeline side (drives address, data, access type, request)
//   slave  : the memory side (drives acknowledge and read data)
// Signals:
//   memAddr, memWriteData : address and store data, valid while memReq=1
//   memRead, memWrite     : access type, qualified by memReq
//   memReq                : access request
//   memAck                : access complete, memReadData valid same cycle
//   memReadData           : load data
// ---------------------------------------------------------------------------
interface mem_stage_if #(
    parameter int N = 64
);

    logic [N-1:0] memAddr;
    logic [N-1:0] memWriteData;
    logic         memRead;
    logic         memWrite;
    logic         memReq;
    logic         memAck;
    logic [N-1:0] memReadData;

    modport master (
        output memAddr,
        output memWriteData,
        output memRead,
        output memWrite,
        output memReq,
        input  memAck,
        input  memReadData
    );

    modport slave (
        input  memAddr,
        input  memWriteData,
        input  memRead,
        input  memWrite,
        input  memReq,
        output memAck,
        output memReadData
    );

endinterface

// File: rtl/mem_access_fsm.sv
// ---------------------------------------------------------------------------
// mem_access_fsm
// Data-memory request/acknowledge controller with a timeout watchdog.
// Ports:
//   clk, reset : core clock (rising edge), asynchronous active-low reset
//   mem_op     : the instruction in M is a valid load or store
//   mem_ack    : memory acknowledge
//   mem_req    : request to memory (suppressed once faulted)
//   stall      : freeze upstream stages
//   fault      : sticky timeout fault, cleared only by reset
// ---------------------------------------------------------------------------
module mem_access_fsm #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_op,
    input  logic mem_ack,
    output logic mem_req,
    output logic stall,
    output logic fault
);

    import pipe_pkg::*;

    localparam int                CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    mem_state_t       state;
    mem_state_t       state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // The counter holds the number of request cycles already spent without
    // an acknowledge; the access gives up after TIMEOUT such cycles.
    always_comb begin
        state_next = state;
        count_next = count;
        unique case (state)
            IDLE: begin
                if (mem_op && !mem_ack) begin
                    state_next = BUSY;
                    count_next = CNT_W'(1);
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_next = IDLE;
                    count_next = '0;
                end else begin
                    count_next = count + CNT_W'(1);
                    if (count == LAST_WAIT) begin
                        state_next = FAULT;
                    end
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_comb begin
        fault   = (state == FAULT);
        mem_req = mem_op && (state != FAULT);
        stall   = (mem_req && !mem_ack) || fault;
    end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory stage of the pipelined LEGv8 core: EX/MEM register, data-memory
// access control, branch resolution and MEM/WB register.
// Ports:
//   clk, reset        : core clock, asynchronous active-low reset
//   *_E               : instruction leaving execute (valid, flush, branch
//                       target, ALU result/address, store data, zero flag,
//                       control bits, destination register)
//   mem               : data-memory bus (master side)
//   stall_M           : freeze fetch/decode/execute registers
//   PCSrc_M, PCBranch_M : branch decision and target
//   *_W               : results handed to write-back
//   fault_M           : sticky memory-timeout fault
// ---------------------------------------------------------------------------
module mem_stage
    import pipe_pkg::*;
#(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             valid_E,
    input  logic             flush_E,
    input  logic [N-1:0]     PCBranch_E,
    input  logic [N-1:0]     aluResult_E,
    input  logic [N-1:0]     writeData_E,
    input  logic             zero_E,
    input  logic             branch_E,
    input  logic             memRead_E,
    input  logic             memWrite_E,
    input  logic             regWrite_E,
    input  logic             memtoReg_E,
    input  logic [REG_W-1:0] rd_E,

    mem_stage_if.master      mem,

    output logic             stall_M,
    output logic             PCSrc_M,
    output logic [N-1:0]     PCBranch_M,
    output logic [N-1:0]     readData_W,
    output logic [N-1:0]     aluResult_W,
    output logic [REG_W-1:0] rd_W,
    output logic             regWrite_W,
    output logic             memtoReg_W,
    output logic             valid_W,
    output logic             fault_M
);

    logic             valid_m;
    ctrl_m_t          ctrl_m;
    logic [N-1:0]     alu_m;
    logic [N-1:0]     write_data_m;
    logic             zero_m;
    logic [REG_W-1:0] rd_m;
    logic             mem_op;
    logic             mem_req;

    // EX/MEM register. While stalled the instruction in M is held, so a
    // flush arriving during a stall cannot touch it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_m      <= 1'b0;
            ctrl_m       <= '0;
            alu_m        <= '0;
            write_data_m <= '0;
            zero_m       <= 1'b0;
            rd_m         <= '0;
            PCBranch_M   <= '0;
        end else if (!stall_M) begin
            valid_m      <= valid_E & ~flush_E;
            ctrl_m       <= '{branch:   branch_E,
                              memRead:  memRead_E,
                              memWrite: memWrite_E,
                              regWrite: regWrite_E,
                              memtoReg: memtoReg_E};
            alu_m        <= aluResult_E;
            write_data_m <= writeData_E;
            zero_m       <= zero_E;
            rd_m         <= rd_E;
            PCBranch_M   <= PCBranch_E;
        end
    end

    assign mem_op = valid_m & (ctrl_m.memRead | ctrl_m.memWrite);

    mem_access_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_fsm (
        .clk     (clk),
        .reset   (reset),
        .mem_op  (mem_op),
        .mem_ack (mem.memAck),
        .mem_req (mem_req),
        .stall   (stall_M),
        .fault   (fault_M)
    );

    // Bus fields are gated by the request so the memory never sees a
    // stale address or access type from an idle or faulted stage.
    assign mem.memReq       = mem_req;
    assign mem.memAddr      = mem_req ? alu_m : '0;
    assign mem.memWriteData = mem_req ? write_data_m : '0;
    assign mem.memRead      = mem_req & ctrl_m.memRead;
    assign mem.memWrite     = mem_req & ctrl_m.memWrite;

    assign PCSrc_M = valid_m & ctrl_m.branch & zero_m;

    // MEM/WB register. A stall edge inserts a bubble so an instruction held
    // in M for several cycles reaches write-back exactly once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readData_W  <= '0;
            aluResult_W <= '0;
            rd_W        <= '0;
            regWrite_W  <= 1'b0;
            memtoReg_W  <= 1'b0;
            valid_W     <= 1'b0;
        end else if (!stall_M) begin
            readData_W  <= ctrl_m.memRead ? mem.memReadData : '0;
            aluResult_W <= alu_m;
            rd_W        <= rd_m;
            regWrite_W  <= valid_m & ctrl_m.regWrite;
            memtoReg_W  <= ctrl_m.memtoReg;
            valid_W     <= valid_m;
        end else begin
            regWrite_W  <= 1'b0;
            valid_W     <= 1'b0;
        end
    end

endmodule
